// File: rtl/knock_pkg.sv
// Shared definitions for the knock pattern detector: FSM state encodings,
// default timing constants and a timer-width helper.
package knock_pkg;

  // Detector states; the fourth encoding is unreachable and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_LOCK  = 2'd2
  } knock_state_e;

  // Default timing, all in 1 kHz clock cycles (milliseconds).
  localparam int DEF_DEB_MS    = 20;
  localparam int DEF_GAP_MS    = 1000;
  localparam int DEF_KNOCK_NUM = 3;
  localparam int DEF_LOCK_MS   = 4096;

  // Width of an up-counter whose terminal value is n-1; never below 1 bit.
  function automatic int tmr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/knock_debounce.sv
// Knock input conditioning: 2-flop synchronizer, level debouncer and
// rising-edge detector. knock_evt_o is a registered single-cycle pulse that
// is high in the same cycle the debounced level becomes 1.
module knock_debounce
  import knock_pkg::*;
#(
  parameter int DEB_MS = DEF_DEB_MS
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic knock_i,
  output logic knock_evt_o
);

  localparam int               CNT_W    = tmr_width(DEB_MS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_MS - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             evt_q;
  logic             evt_d;

  // Bring the raw sensor into the clock domain before anything looks at it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= knock_i;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  // On the DEB_MS-th cycle the level flips and a 0->1 flip raises the event.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    evt_d   = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        evt_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign knock_evt_o = evt_q;

endmodule

// File: rtl/knock_pattern_detect.sv
// Knock pattern detector: counts debounced knocks that arrive within GAP_MS
// of each other and pulses ALARM once KNOCK_NUM of them have been seen, then
// ignores knocks for LOCK_MS cycles while the buzzer sequence plays.
// Optional feature macro: KNOCK_LED_EN -- LED_OUT stretches each accepted
// knock to 100 cycles and stays lit during LOCK; otherwise LED_OUT is 0.
module knock_pattern_detect
  import knock_pkg::*;
#(
  parameter int DEB_MS    = DEF_DEB_MS,
  parameter int GAP_MS    = DEF_GAP_MS,
  parameter int KNOCK_NUM = DEF_KNOCK_NUM,
  parameter int LOCK_MS   = DEF_LOCK_MS
) (
  input  logic       CLK1K,
  input  logic       RSTN,
  input  logic       KNOCK_IN,
  output logic       ALARM,
  output logic [3:0] KNOCK_CNT,
  output logic       LED_OUT
);

  localparam int                GAP_W     = tmr_width(GAP_MS);
  localparam int                LOCK_W    = tmr_width(LOCK_MS);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_MS - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_MS - 1);
  localparam logic [3:0]        NUM_C     = 4'(KNOCK_NUM);

  logic              knock_evt;
  knock_state_e      state_q;
  knock_state_e      state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        cnt_d;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_d;
  logic [LOCK_W-1:0] lock_q;
  logic [LOCK_W-1:0] lock_d;
  logic              alarm_q;
  logic              alarm_d;

  knock_debounce #(
    .DEB_MS (DEB_MS)
  ) u_debounce (
    .clk_i       (CLK1K),
    .rst_ni      (RSTN),
    .knock_i     (KNOCK_IN),
    .knock_evt_o (knock_evt)
  );

  // Next-state logic. ALARM is only requested on the transition into LOCK,
  // and LOCK never requests it, so it can never be high two cycles running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    lock_d  = lock_q;
    alarm_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (knock_evt) begin
          gap_d = '0;
          if (KNOCK_NUM == 1) begin
            state_d = ST_LOCK;
            cnt_d   = NUM_C;
            lock_d  = '0;
            alarm_d = 1'b1;
          end else begin
            state_d = ST_COUNT;
            cnt_d   = 4'd1;
          end
        end
      end
      ST_COUNT: begin
        // A knock in the same cycle as the gap expiry takes priority.
        if (knock_evt) begin
          gap_d = '0;
          if (cnt_q + 4'd1 == NUM_C) begin
            state_d = ST_LOCK;
            cnt_d   = NUM_C;
            lock_d  = '0;
            alarm_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_LOCK: begin
        // Knocks are ignored; the lock timer runs LOCK_MS cycles from entry.
        if (lock_q == LOCK_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          lock_d  = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        gap_d   = '0;
        lock_d  = '0;
      end
    endcase
  end

  // FSM state, counters and the registered ALARM pulse.
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      gap_q   <= '0;
      lock_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      lock_q  <= lock_d;
      alarm_q <= alarm_d;
    end
  end

  assign ALARM     = alarm_q;
  assign KNOCK_CNT = cnt_q;

`ifdef KNOCK_LED_EN
  localparam int LED_STRETCH = 100;

  logic [6:0] led_cnt_q;
  logic [6:0] led_cnt_d;
  logic       knock_acc;

  // A knock is accepted whenever it is not swallowed by LOCK.
  assign knock_acc = knock_evt && (state_q != ST_LOCK);

  // Stretch counter: every accepted knock restarts the full 100-cycle window.
  always_comb begin
    led_cnt_d = led_cnt_q;
    if (knock_acc) begin
      led_cnt_d = 7'(LED_STRETCH);
    end else if (led_cnt_q != 7'd0) begin
      led_cnt_d = led_cnt_q - 7'd1;
    end
  end

  // Stretch counter register.
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      led_cnt_q <= 7'd0;
    end else begin
      led_cnt_q <= led_cnt_d;
    end
  end

  assign LED_OUT = (led_cnt_q != 7'd0) || (state_q == ST_LOCK);
`else
  assign LED_OUT = 1'b0;
`endif

endmodule
